// File: rtl/pea_token_fetch_pkg.sv
// Shared definitions for the PEA firing engine: mode encodings, opcodes,
// command token field positions and a ceiling-log2 helper.
package pea_defs;

    typedef enum logic [2:0] {
        MODE_GET_COMMAND = 3'b000,
        MODE_STP         = 3'b001,
        MODE_EVP         = 3'b010,
        MODE_EVB         = 3'b011,
        MODE_RST         = 3'b100,
        MODE_OUTPUT      = 3'b101
    } mode_t;

    localparam logic [7:0] OP_STP = 8'h01;
    localparam logic [7:0] OP_EVP = 8'h02;
    localparam logic [7:0] OP_EVB = 8'h03;
    localparam logic [7:0] OP_RST = 8'h04;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 8;
    localparam int ARG1_MSB = 7;
    localparam int ARG1_LSB = 5;
    localparam int ARG2_MSB = 4;
    localparam int ARG2_LSB = 0;

    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/pea_token_fetch_if.sv
// FIFO pop ports, coefficient/evaluator strobes and status of the firing engine.
interface pea_token_fetch_if
    import pea_defs::*;
#(
    parameter int word_size   = 16,
    parameter int num_vectors = 8,
    parameter int max_coef    = 16
);
    localparam int aw = log2(num_vectors) + log2(max_coef);

    logic                 invoke;
    logic                 cmd_rd_en;
    logic [word_size-1:0] cmd_data;
    logic                 data_rd_en;
    logic [word_size-1:0] data_in;
    logic [2:0]           mode;
    logic [4:0]           b;
    logic [3:0]           N;
    logic                 coef_wr_en;
    logic [aw-1:0]        coef_wr_addr;
    logic [word_size-1:0] coef_wr_data;
    logic                 x_valid;
    logic [word_size-1:0] x_data;
    logic [4:0]           x_index;
    logic                 clear_all;
    logic                 err_cmd;
    logic                 done;

    modport master (
        input  invoke, cmd_data, data_in,
        output cmd_rd_en, data_rd_en, mode, b, N, coef_wr_en, coef_wr_addr,
               coef_wr_data, x_valid, x_data, x_index, clear_all, err_cmd, done
    );

    modport slave (
        output invoke, cmd_data, data_in,
        input  cmd_rd_en, data_rd_en, mode, b, N, coef_wr_en, coef_wr_addr,
               coef_wr_data, x_valid, x_data, x_index, clear_all, err_cmd, done
    );

endinterface

// File: rtl/pea_token_fetch_degree_table.sv
// Per-vector polynomial degree registers with synchronous clear and one write port.
module pea_degree_table
    import pea_defs::*;
#(
    parameter int num_vectors = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic [log2(num_vectors)-1:0] wr_addr,
    input  logic [3:0]                   wr_data,
    input  logic [log2(num_vectors)-1:0] rd_addr,
    output logic [3:0]                   rd_data
);

    logic [3:0] deg [num_vectors];

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            for (int i = 0; i < num_vectors; i++) deg[i] <= '0;
        end else if (wr_en) begin
            deg[wr_addr] <= wr_data;
        end
    end

    assign rd_data = deg[rd_addr];

endmodule

// File: rtl/pea_token_fetch.sv
// PEA firing engine: pops one command, decodes it, pops the data tokens the mode
// consumes and steers them to coefficient storage or the evaluator.
//
// state     | meaning
// S_IDLE    | waiting for invoke
// S_CMD_POP | command FIFO pop
// S_CMD_LATCH | command head valid, decode
// S_FETCH   | back-to-back data pops, writes trail by one cycle
// S_FINISH  | done pulse, degree table update for STP
module pea_token_fetch
    import pea_defs::*;
#(
    parameter int word_size   = 16,
    parameter int buffer_size = 1024,
    parameter int num_vectors = 8,
    parameter int max_coef    = 16
) (
    input  logic               clk,
    input  logic               rst,
    pea_token_fetch_if.master  bus
);

    localparam int cnt_w = log2(buffer_size);
    localparam int vw    = log2(num_vectors);
    localparam int cw    = log2(max_coef);

    typedef enum logic [2:0] {S_IDLE, S_CMD_POP, S_CMD_LATCH, S_FETCH, S_FINISH} state_t;

    state_t               state;
    mode_t                mode_q, op_q, dec_mode;
    logic                 dec_valid;
    logic [cnt_w-1:0]     dec_count, pops_left;
    logic [word_size-1:0] cmd;
    logic [7:0]           opc;
    logic [2:0]           arg1;
    logic [4:0]           arg2;
    logic [vw-1:0]        vec_q, rd_vec;
    logic [4:0]           pop_idx, x_index_q, b_q;
    logic [3:0]           n_q, deg_rd;
    logic [vw+cw-1:0]     wr_addr_q;
    logic                 cmd_rd_en_q, data_rd_en_q, coef_wr_en_q, x_valid_q;
    logic                 clear_all_q, err_cmd_q, done_q, deg_wr_en;

    assign cmd    = bus.cmd_data;
    assign opc    = cmd[OPC_MSB:OPC_LSB];
    assign arg1   = cmd[ARG1_MSB:ARG1_LSB];
    assign arg2   = cmd[ARG2_MSB:ARG2_LSB];
    assign rd_vec = vw'(arg1);

    always_comb begin
        dec_valid = 1'b1;
        dec_mode  = MODE_GET_COMMAND;
        dec_count = '0;
        case (opc)
            OP_STP: begin dec_mode = MODE_STP; dec_count = cnt_w'(arg2[3:0]) + cnt_w'(1); end
            OP_EVP: begin dec_mode = MODE_EVP; dec_count = cnt_w'(1); end
            OP_EVB: begin dec_mode = MODE_EVB; dec_count = cnt_w'(arg2); end
            OP_RST: dec_mode = MODE_RST;
            default: dec_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            mode_q       <= MODE_GET_COMMAND;
            op_q         <= MODE_GET_COMMAND;
            vec_q        <= '0;
            pops_left    <= '0;
            pop_idx      <= '0;
            x_index_q    <= '0;
            b_q          <= '0;
            n_q          <= '0;
            wr_addr_q    <= '0;
            cmd_rd_en_q  <= 1'b0;
            data_rd_en_q <= 1'b0;
            coef_wr_en_q <= 1'b0;
            x_valid_q    <= 1'b0;
            clear_all_q  <= 1'b0;
            err_cmd_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            cmd_rd_en_q  <= 1'b0;
            coef_wr_en_q <= 1'b0;
            x_valid_q    <= 1'b0;
            clear_all_q  <= 1'b0;
            err_cmd_q    <= 1'b0;
            done_q       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.invoke) begin
                        state       <= S_CMD_POP;
                        cmd_rd_en_q <= 1'b1;
                        mode_q      <= MODE_GET_COMMAND;
                    end
                end
                S_CMD_POP: state <= S_CMD_LATCH;
                S_CMD_LATCH: begin
                    if (!dec_valid) begin
                        op_q      <= MODE_GET_COMMAND;
                        err_cmd_q <= 1'b1;
                        done_q    <= 1'b1;
                        state     <= S_FINISH;
                    end else begin
                        mode_q       <= dec_mode;
                        op_q         <= dec_mode;
                        vec_q        <= rd_vec;
                        b_q          <= arg2;
                        pops_left    <= dec_count;
                        data_rd_en_q <= (dec_count != '0);
                        pop_idx      <= '0;
                        clear_all_q  <= (dec_mode == MODE_RST);
                        case (dec_mode)
                            MODE_STP:           n_q <= arg2[3:0];
                            MODE_EVP, MODE_EVB: n_q <= deg_rd;
                            default:            n_q <= '0;
                        endcase
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (data_rd_en_q) begin
                        pops_left    <= pops_left - cnt_w'(1);
                        data_rd_en_q <= (pops_left > cnt_w'(1));
                        pop_idx      <= pop_idx + 5'd1;
                        coef_wr_en_q <= (op_q == MODE_STP);
                        x_valid_q    <= (op_q == MODE_EVP) || (op_q == MODE_EVB);
                        wr_addr_q    <= {vec_q, pop_idx[cw-1:0]};
                        x_index_q    <= pop_idx;
                    end else begin
                        // No pop this cycle: the last write (if any) is landing now.
                        state  <= S_FINISH;
                        done_q <= 1'b1;
                        mode_q <= ((op_q == MODE_EVP) || (op_q == MODE_EVB)) ? MODE_OUTPUT
                                                                             : MODE_GET_COMMAND;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign deg_wr_en = (state == S_FINISH) && (op_q == MODE_STP);

    pea_degree_table #(.num_vectors(num_vectors)) u_degree_table (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_all_q),
        .wr_en   (deg_wr_en),
        .wr_addr (vec_q),
        .wr_data (n_q),
        .rd_addr (rd_vec),
        .rd_data (deg_rd)
    );

    assign bus.cmd_rd_en    = cmd_rd_en_q;
    assign bus.data_rd_en   = data_rd_en_q;
    assign bus.mode         = mode_q;
    assign bus.b            = b_q;
    assign bus.N            = n_q;
    assign bus.coef_wr_en   = coef_wr_en_q;
    assign bus.coef_wr_addr = wr_addr_q;
    assign bus.coef_wr_data = bus.data_in;
    assign bus.x_valid      = x_valid_q;
    assign bus.x_data       = bus.data_in;
    assign bus.x_index      = x_index_q;
    assign bus.clear_all    = clear_all_q;
    assign bus.err_cmd      = err_cmd_q;
    assign bus.done         = done_q;

endmodule

// File: doc/pea_token_fetch.md
Name: pea_token_fetch

Overview:
- Consumer-side firing engine of the Polynomial Evaluation Accelerator (PEA) actor.
- Sits after the actor's enable logic. When the controller invokes the actor, this block pops one command token from the command FIFO and decodes it.
- It then pops the exact number of data tokens the decoded mode consumes, and steers them to coefficient storage or the evaluation datapath.
- It reports the mode it executed and a one-cycle done pulse, so the controller can select the next firing condition.

Parameters:
- word_size, 16, bit width of command and data tokens.
- buffer_size, 1024, words per FIFO; sets the pointer/count width log2(buffer_size).
- num_vectors, 8, number of coefficient vectors held in the coefficient store.
- max_coef, 16, coefficients per vector (degree N up to 15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- invoke  in  1  one-cycle pulse; the controller has confirmed that enable is high for the current mode.
- cmd_rd_en  out  1  command FIFO pop.
- cmd_data  in  word_size  command FIFO head; valid the cycle after cmd_rd_en.
- data_rd_en  out  1  data FIFO pop.
- data_in  in  word_size  data FIFO head; valid the cycle after data_rd_en.
- mode  out  3  current mode: GET_COMMAND=000, STP=001, EVP=010, EVB=011, RST=100, OUTPUT=101.
- b  out  5  registered arg2 (token count for EVB/OUTPUT).
- N  out  4  degree of the currently selected vector.
- coef_wr_en  out  1  coefficient store write strobe.
- coef_wr_addr  out  log2(num_vectors)+log2(max_coef)  address = {vector_id, index}.
- coef_wr_data  out  word_size  coefficient value.
- x_valid  out  1  x token strobe to the evaluator.
- x_data  out  word_size  x value.
- x_index  out  5  position of x within the batch, 0-based.
- clear_all  out  1  one-cycle pulse on RST command; clears the coefficient store valid bits.
- err_cmd  out  1  one-cycle pulse when a command is invalid.
- done  out  1  one-cycle pulse at the end of the firing.

Behaviour:
- Reset (rst=0 at a clk edge):
  - FSM goes to IDLE.
  - mode=GET_COMMAND.
  - All strobes, done, err_cmd and clear_all are 0.
  - b=0, N=0, x_index=0, coef_wr_addr=0.
  - The degree table is cleared to 0.
  - Reset mid-firing abandons the firing immediately; no further pops are issued.
- Command token layout: [15:8] opcode, [7:5] arg1 (vector id), [4:0] arg2.
  - Opcodes: 0x01 STP, 0x02 EVP, 0x03 EVB, 0x04 RST. Any other opcode is invalid.
- FSM states: IDLE, CMD_POP, CMD_LATCH, FETCH, FINISH.
  - IDLE: wait for invoke. Ignore invoke in every other state.
  - CMD_POP: assert cmd_rd_en for exactly 1 cycle.
  - CMD_LATCH: capture cmd_data and decode it.
    - STP: N_reg=arg2[3:0]; count=N+1.
    - EVP: count=1.
    - EVB: count=arg2.
    - RST: count=0.
    - Invalid: pulse err_cmd and go to FINISH with mode unchanged (GET_COMMAND).
    - Set mode to the decoded value.
  - FETCH: assert data_rd_en on consecutive cycles until count pops have been issued (no bubbles).
    - Each returned word arrives 1 cycle after its pop and is written with one strobe per word.
    - STP: coef_wr_en, addr={arg1, index}.
    - EVP/EVB: x_valid, x_index=index.
    - The last write lands on the cycle after the last pop; the FSM leaves FETCH on that cycle.
  - FINISH: pulse done for 1 cycle and return to IDLE.
    - For STP, write degree_table[arg1]=N on this cycle.
    - For EVP/EVB, mode becomes OUTPUT at the done pulse and stays OUTPUT until the next invoke, when it returns to GET_COMMAND.
    - For STP/RST/invalid, mode returns to GET_COMMAND.
- RST: pulse clear_all in CMD_LATCH+1, zero the degree table, pop no data, then FINISH.
- EVB with arg2=0: no pops; done 2 cycles after CMD_LATCH. Same for count=0 in general.
- The N output for EVP/EVB is degree_table[arg1], registered in CMD_LATCH.
- The block never checks FIFO population; the enable logic guarantees it.
- Latency for count k≥1: invoke at cycle 0; cmd_rd_en at 1; latch at 2; first pop at 3; last write at 3+k; done at 4+k.
- No pop is ever issued outside CMD_POP/FETCH.

Decomposition:
- Shared package pea_defs: mode encodings, opcode constants, token field positions, and the log2 function.
- One sub-module: pea_degree_table, num_vectors×4-bit registers with sync clear and one write port.

Test Plan:
- STP, arg1=3, N=2, with data tokens 5, -1, 7:
  - exactly 1 cmd pop and 3 data pops;
  - coef writes at addr 48, 49, 50 with values 5, -1, 7;
  - done at cycle 7; degree_table[3]=2.
- EVP on vector 3 after the STP case, with x=4:
  - one x_valid, x_index=0, N=2;
  - done at cycle 5; mode=OUTPUT after done.
- EVB with b=5, x=1..5:
  - 5 back-to-back pops; x_index 0..4;
  - done at cycle 9; b output=5.
- RST:
  - clear_all pulse, zero data pops, all degree entries=0, done at cycle 4.
- Opcode 0x7F:
  - err_cmd pulse, no data pops, mode stays GET_COMMAND, done asserted.
- Reset (rst=0 for 1 cycle) asserted during the third pop of EVB b=10:
  - no further pops; all outputs return to their reset values the next cycle.
- A second invoke mid-firing is ignored.
